// File: rtl/mult_div_unit_if.sv
// Purpose: groups the request, MTHI/MTLO and result signals exchanged between
// the ALU stage and the multiply/divide unit.
// Ports (signals):
//   start, op, src_a, src_b   operation request from the ALU stage
//   mthi_en, mtlo_en, wdata   direct HI/LO writes
//   busy, done, hi, lo        status and architectural HI/LO values
// Modports: master = ALU stage side, slave = multiply/divide unit side.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi_en;
    logic             mtlo_en;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi_en, mtlo_en, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi_en, mtlo_en, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU produce the full 2*WIDTH product in {hi,lo}; DIV/DIVU produce
// quotient in lo and remainder in hi. One iteration per cycle on magnitudes,
// with the sign applied in a final FIX cycle.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     mult_div_unit_if slave modport (request, MTHI/MTLO, busy/done/hi/lo)
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_div_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_a_q, neg_a_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;

    // Operand magnitudes and signs; op[0]=0 selects the signed variants.
    always_comb begin
        sign_a = ~bus.op[0] & bus.src_a[WIDTH-1];
        sign_b = ~bus.op[0] & bus.src_b[WIDTH-1];
        abs_a  = sign_a ? (~bus.src_a + 1'b1) : bus.src_a;
        abs_b  = sign_b ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // One iteration of each algorithm. rem_q holds the product's upper half
    // (multiply) or the partial remainder (divide); low_q holds the multiplier
    // being shifted out or the dividend being shifted into the quotient.
    always_comb begin
        mul_sum   = {1'b0, rem_q} + (low_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {rem_q, low_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift - {1'b0, b_q};
    end

    // Signed results. A zero divisor leaves |a| in the remainder, so the
    // remainder sign fix restores src_a; only the quotient needs forcing.
    always_comb begin
        product  = {rem_q, low_q};
        mul_res  = neg_res_q ? (~product + 1'b1) : product;
        quot_res = div_zero_q ? {WIDTH{1'b1}} :
                   (neg_res_q ? (~low_q + 1'b1) : low_q);
        rem_res  = neg_a_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and datapath control. MTHI/MTLO are applied first so that a
    // result write in FIX overrides them on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_a_d    = neg_a_q;
        div_zero_d = div_zero_q;
        b_d        = b_q;
        rem_d      = rem_q;
        low_d      = low_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        if (bus.mthi_en) begin
            hi_d = bus.wdata;
        end
        if (bus.mtlo_en) begin
            lo_d = bus.wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d   = bus.op[1];
                    neg_res_d  = sign_a ^ sign_b;
                    neg_a_d    = sign_a;
                    div_zero_d = (bus.src_b == '0);
                    b_d        = abs_b;
                    rem_d      = '0;
                    low_d      = abs_a;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], div_ge};
                end else begin
                    rem_d = mul_sum[WIDTH:1];
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quot_res;
                end else begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_a_q    <= 1'b0;
            div_zero_q <= 1'b0;
            b_q        <= '0;
            rem_q      <= '0;
            low_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_a_q    <= neg_a_d;
            div_zero_q <= div_zero_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            low_q      <= low_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Status decoded from the state register; hi/lo come straight from flops.
    always_comb begin
        bus.busy = (state_q == CALC) || (state_q == FIX);
        bus.done = (state_q == DONE);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: directed self-checking bench for mult_div_unit with hand-computed
// expected results for multiply, divide, MTHI/MTLO and reset behaviour.
module tb_mult_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   edges;
    int   busy_cycles;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one operation starting at a falling edge and returns how many
    // rising edges elapsed from accept to done and how many cycles busy was
    // high. Operands are scrambled after accept. Optionally keeps start high
    // through DONE or drives MTLO in the FIX cycle. Returns at a falling edge
    // one cycle after the done pulse.
    task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a,
                                 input logic [31:0] b, input bit hold_start,
                                 input bit mtlo_in_fix, output int n_edges,
                                 output int n_busy);
        bit seen_done;
        seen_done   = 1'b0;
        n_edges     = 0;
        n_busy      = 0;
        bus.op      = op_i;
        bus.src_a   = a;
        bus.src_b   = b;
        bus.start   = 1'b1;
        @(posedge clk);
        n_edges = 1;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        bus.op    = ~op_i;
        bus.src_a = ~a;
        bus.src_b = b + 32'd3;
        for (int i = 0; i < 100 && !seen_done; i++) begin
            if (bus.done) begin
                seen_done = 1'b1;
            end else begin
                if (bus.busy) n_busy++;
                if (mtlo_in_fix && n_edges == 33) begin
                    bus.mtlo_en = 1'b1;
                    bus.wdata   = 32'h55;
                end else begin
                    bus.mtlo_en = 1'b0;
                end
                @(posedge clk);
                n_edges++;
                @(negedge clk);
            end
        end
        bus.mtlo_en = 1'b0;
        checkOutput("done_seen", 64'(seen_done), 64'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
        checkOutput("idle_after_done", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi_en = 1'b0;
        bus.mtlo_en = 1'b0;
        bus.wdata   = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        @(negedge clk);
        bus.mthi_en = 1'b1;
        bus.wdata   = 32'hAA;
        @(negedge clk);
        bus.mthi_en = 1'b0;
        checkOutput("mthi_hi", 64'(bus.hi), 64'hAA);
        checkOutput("mthi_lo_kept", 64'(bus.lo), 64'd0);

        applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("mult_hi", 64'(bus.hi), 64'hFFFFFFFF);
        checkOutput("mult_lo", 64'(bus.lo), 64'hFFFFFFF1);
        checkOutput("mult_latency", 64'(edges), 64'd34);
        checkOutput("mult_busy", 64'(busy_cycles), 64'd33);

        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("multu_hi", 64'(bus.hi), 64'hFFFFFFFE);
        checkOutput("multu_lo", 64'(bus.lo), 64'h00000001);
        checkOutput("multu_busy", 64'(busy_cycles), 64'd33);

        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("div_neg_lo", 64'(bus.lo), 64'hFFFFFFFD);
        checkOutput("div_neg_hi", 64'(bus.hi), 64'hFFFFFFFF);

        applyStimulus(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("div_negb_lo", 64'(bus.lo), 64'hFFFFFFFD);
        checkOutput("div_negb_hi", 64'(bus.hi), 64'h00000001);

        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("divu_lo", 64'(bus.lo), 64'd14);
        checkOutput("divu_hi", 64'(bus.hi), 64'd2);
        checkOutput("divu_latency", 64'(edges), 64'd34);

        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("div_ovf_lo", 64'(bus.lo), 64'h80000000);
        checkOutput("div_ovf_hi", 64'(bus.hi), 64'd0);

        applyStimulus(2'b11, 32'h1234, 32'd0, 1'b1, 1'b0, edges, busy_cycles);
        checkOutput("divu_zero_lo", 64'(bus.lo), 64'hFFFFFFFF);
        checkOutput("divu_zero_hi", 64'(bus.hi), 64'h1234);

        applyStimulus(2'b10, 32'hFFFFFFFB, 32'd0, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("div_zero_lo", 64'(bus.lo), 64'hFFFFFFFF);
        checkOutput("div_zero_hi", 64'(bus.hi), 64'hFFFFFFFB);

        applyStimulus(2'b01, 32'h00010000, 32'h00010000, 1'b0, 1'b1, edges, busy_cycles);
        checkOutput("fix_wins_lo", 64'(bus.lo), 64'd0);
        checkOutput("fix_wins_hi", 64'(bus.hi), 64'd1);

        @(negedge clk);
        bus.op    = 2'b01;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("midop_reset_done", 64'(bus.done), 64'd0);
        checkOutput("midop_reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("midop_reset_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", 64'(bus.busy), 64'd0);

        applyStimulus(2'b00, 32'd6, 32'd7, 1'b0, 1'b0, edges, busy_cycles);
        checkOutput("mult_after_reset_lo", 64'(bus.lo), 64'd42);
        checkOutput("mult_after_reset_hi", 64'(bus.hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
